// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a combinational processor read port, a stallable
// valid/ready debug port, saturating access counters and a sticky protocol-error flag.
module data_mem_responder #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CEN,
  input  logic              WEN,
  input  logic              OEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] Data2Mem,
  output logic [DATA_W-1:0] ReadDataMem,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic              proto_err
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic proc_rd, proc_wr, proc_illegal;
  logic dbg_acc, dbg_wr, dbg_rd;

  logic [DATA_W-1:0] rdata_p1;
  logic              vld_p1;
  logic [CNT_W-1:0]  rd_cnt_p1, wr_cnt_p1;
  logic              err_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign proc_rd      = ~CEN & ~OEN;
  assign proc_wr      = ~CEN & ~WEN;
  assign proc_illegal = proc_rd & proc_wr;

  // Processor owns the array whenever CEN is low, so debug is accepted only when idle.
  assign dbg_ready = CEN;
  assign dbg_acc   = dbg_valid & dbg_ready;
  assign dbg_wr    = dbg_acc & dbg_we;
  assign dbg_rd    = dbg_acc & ~dbg_we;

  // Stage p0: combinational read (old data even on an illegal read+write)
  assign ReadDataMem = proc_rd ? mem[A] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (proc_wr) begin
      mem[A] <= Data2Mem;
    end else if (dbg_wr) begin
      mem[dbg_addr] <= dbg_wdata;
    end
  end

  // Stage p1: registered debug read data, counters and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_p1  <= '0;
      vld_p1    <= 1'b0;
      rd_cnt_p1 <= '0;
      wr_cnt_p1 <= '0;
      err_p1    <= 1'b0;
    end else begin
      vld_p1 <= dbg_rd;
      if (dbg_rd)       rdata_p1  <= mem[dbg_addr];
      if (proc_rd)      rd_cnt_p1 <= sat_inc(rd_cnt_p1);
      if (proc_wr)      wr_cnt_p1 <= sat_inc(wr_cnt_p1);
      if (proc_illegal) err_p1    <= 1'b1;
    end
  end

  assign dbg_rdata  = rdata_p1;
  assign dbg_rvalid = vld_p1;
  assign rd_count   = rd_cnt_p1;
  assign wr_count   = wr_cnt_p1;
  assign proto_err  = err_p1;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized bench for data_mem_responder against an array-based
// reference model; built with CNT_W=2 so counter saturation is reachable quickly.
module tb_data_mem_responder;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              CEN, WEN, OEN;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] Data2Mem;
  logic [DATA_W-1:0] ReadDataMem;
  logic              dbg_valid, dbg_ready, dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
  logic              dbg_rvalid;
  logic [CNT_W-1:0]  rd_count, wr_count;
  logic              proto_err;

  data_mem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A),
    .Data2Mem(Data2Mem), .ReadDataMem(ReadDataMem), .dbg_valid(dbg_valid),
    .dbg_ready(dbg_ready), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid), .rd_count(rd_count),
    .wr_count(wr_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DATA_W-1:0] m_mem [DEPTH];
  int                m_rd, m_wr;
  logic              m_err, m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_rd = 0; m_wr = 0; m_err = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
  endtask

  task automatic idle();
    CEN = 1'b1; WEN = 1'b1; OEN = 1'b1; A = '0; Data2Mem = '0;
    dbg_valid = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".rvalid"}, 32'(dbg_rvalid), 32'(m_rvalid));
    chk({tag, ".rdata"},  dbg_rdata, m_rdata);
    chk({tag, ".rd_cnt"}, 32'(rd_count), 32'(m_rd));
    chk({tag, ".wr_cnt"}, 32'(wr_count), 32'(m_wr));
    chk({tag, ".err"},    32'(proto_err), 32'(m_err));
  endtask

  // One clock cycle with the currently driven inputs; checks comb outputs mid-cycle
  // and registered outputs just after the edge.
  task automatic cycle(input string tag);
    logic rd, wr, acc;
    logic [DATA_W-1:0] exp_rd;
    @(negedge clk);
    rd  = !CEN && !OEN;
    wr  = !CEN && !WEN;
    acc = dbg_valid && CEN;
    exp_rd = rd ? m_mem[A] : '0;
    chk({tag, ".rdm"},   ReadDataMem, exp_rd);
    chk({tag, ".ready"}, 32'(dbg_ready), 32'(CEN));
    m_rvalid = acc && !dbg_we;
    if (m_rvalid) m_rdata = m_mem[dbg_addr];
    if (rd) m_rd = (m_rd < CMAX) ? m_rd + 1 : CMAX;
    if (wr) m_wr = (m_wr < CMAX) ? m_wr + 1 : CMAX;
    if (rd && wr) m_err = 1'b1;
    if (wr) m_mem[A] = Data2Mem;
    else if (acc && dbg_we) m_mem[dbg_addr] = dbg_wdata;
    @(posedge clk); #1;
    chk_regs(tag);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    #12;
    chk_regs("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: debug preload then processor read
    dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 7'd5; dbg_wdata = 32'hDEADBEEF;
    cycle("t1_dbgwr");
    idle(); CEN = 1'b0; OEN = 1'b0; A = 7'd5;
    cycle("t1_rd");
    chk("t1_rdcnt_abs", 32'(rd_count), 32'd1);

    // 2: processor write, then debug read back
    idle(); CEN = 1'b0; WEN = 1'b0; A = 7'd127; Data2Mem = 32'h12345678;
    cycle("t2_wr");
    idle(); dbg_valid = 1'b1; dbg_addr = 7'd127;
    cycle("t2_dbgrd");
    chk("t2_rdata_abs", dbg_rdata, 32'h12345678);
    idle();
    cycle("t2_hold");
    chk("t2_hold_abs", dbg_rdata, 32'h12345678);

    // 3: debug write stalled by processor for 3 cycles
    idle(); dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 7'd3; dbg_wdata = 32'hA5A5_0003;
    CEN = 1'b0;
    for (int i = 0; i < 3; i++) cycle("t3_stall");
    CEN = 1'b1;
    cycle("t3_accept");
    idle(); CEN = 1'b0; OEN = 1'b0; A = 7'd3;
    cycle("t3_verify");

    // 4: illegal request sets sticky error
    idle(); CEN = 1'b0; OEN = 1'b0; WEN = 1'b0; A = 7'd5; Data2Mem = 32'h0BAD_0005;
    cycle("t4_illegal");
    idle();
    for (int i = 0; i < 10; i++) cycle("t4_sticky");
    chk("t4_err_abs", 32'(proto_err), 32'd1);

    // 5: reads up to and past saturation
    idle(); CEN = 1'b0; OEN = 1'b0; A = 7'd127;
    for (int i = 0; i < 4; i++) cycle("t5_sat");
    chk("t5_sat_abs", 32'(rd_count), 32'(CMAX));

    // 6: asynchronous reset right after a debug read is accepted
    idle(); dbg_valid = 1'b1; dbg_addr = 7'd127;
    @(negedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_regs("t6_async");
    chk("t6_rvalid_abs", 32'(dbg_rvalid), 32'd0);
    idle();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i += 9) begin
      idle(); CEN = 1'b0; OEN = 1'b0; A = ADDR_W'(i);
      cycle("t6_mem0");
    end
    idle(); dbg_valid = 1'b1; dbg_addr = 7'd5;
    cycle("t6_dbg0");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      CEN       = ($urandom_range(0, 2) == 0);
      WEN       = ($urandom_range(0, 2) != 0);
      OEN       = ($urandom_range(0, 1) != 0);
      A         = ADDR_W'($urandom_range(0, 15));
      Data2Mem  = $urandom;
      dbg_valid = ($urandom_range(0, 1) != 0);
      dbg_we    = ($urandom_range(0, 1) != 0);
      dbg_addr  = ADDR_W'($urandom_range(0, 15));
      dbg_wdata = $urandom;
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
